// File: rtl/lcd_pattern_timing_pkg.sv
// Shared definitions for the LCD pattern/timing generator: the pattern mode
// encodings, the eight-entry colour-bar table and the default 480x272 panel
// timing. Imported by the interface, the sync counter and the top level.
package lcd_pattern_timing_pkg;

    typedef enum logic [2:0] {
        MODE_BLACK      = 3'd0,
        MODE_BARS       = 3'd1,
        MODE_RAMP       = 3'd2,
        MODE_CHECKER    = 3'd3,
        MODE_BORDER     = 3'd4,
        MODE_MOVING_BAR = 3'd5,
        MODE_RSVD6      = 3'd6,
        MODE_RSVD7      = 3'd7
    } mode_e;

    // Default 480x272 panel timing
    localparam int unsigned DEF_H_DISP = 480;
    localparam int unsigned DEF_H_FP   = 2;
    localparam int unsigned DEF_H_SYNC = 41;
    localparam int unsigned DEF_H_BP   = 2;
    localparam int unsigned DEF_V_DISP = 272;
    localparam int unsigned DEF_V_FP   = 2;
    localparam int unsigned DEF_V_SYNC = 10;
    localparam int unsigned DEF_V_BP   = 2;

    localparam int unsigned NUM_BARS = 8;

    // {R,G,B} channel on/off per bar, left to right:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [NUM_BARS] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/lcd_pattern_timing_if.sv
// Parallel RGB LCD video bus.
//   master: generator side (drives everything)
//   slave : panel side (observes everything)
// Signals: lcd_hsync/lcd_vsync (sync), lcd_de (data enable), LCD_R/G/B
// (pixel colour), lcd_x/lcd_y (active coordinate), frame_start (pulse on
// pixel 0,0).
interface lcd_pattern_timing_if #(
    parameter int unsigned R_W = 5,
    parameter int unsigned G_W = 6,
    parameter int unsigned B_W = 5
);
    logic           lcd_hsync;
    logic           lcd_vsync;
    logic           lcd_de;
    logic [R_W-1:0] LCD_R;
    logic [G_W-1:0] LCD_G;
    logic [B_W-1:0] LCD_B;
    logic [10:0]    lcd_x;
    logic [10:0]    lcd_y;
    logic           frame_start;

    modport master (
        output lcd_hsync, lcd_vsync, lcd_de, LCD_R, LCD_G, LCD_B,
               lcd_x, lcd_y, frame_start
    );

    modport slave (
        input lcd_hsync, lcd_vsync, lcd_de, LCD_R, LCD_G, LCD_B,
              lcd_x, lcd_y, frame_start
    );
endinterface

// File: rtl/lcd_sync_counter.sv
// Horizontal/vertical timing counters with registered sync, data-enable,
// coordinate and frame-start outputs.
// Ports:
//   clk, rst_n        pixel clock, synchronous active-low reset
//   enable_i          0 holds the counters at 0 and the outputs idle
//   h_cnt_o, v_cnt_o  current counter state (for colour generation)
//   active_o          current counter state lies in the active area
//   line_last_o       last cycle of a line
//   frame_last_o      last cycle of a frame
//   hsync_o, vsync_o, de_o, x_o, y_o, frame_start_o
//                     registered, one clock after the counter state
module lcd_sync_counter
    import lcd_pattern_timing_pkg::*;
#(
    parameter int unsigned H_DISP = DEF_H_DISP,
    parameter int unsigned H_FP   = DEF_H_FP,
    parameter int unsigned H_SYNC = DEF_H_SYNC,
    parameter int unsigned H_BP   = DEF_H_BP,
    parameter int unsigned V_DISP = DEF_V_DISP,
    parameter int unsigned V_FP   = DEF_V_FP,
    parameter int unsigned V_SYNC = DEF_V_SYNC,
    parameter int unsigned V_BP   = DEF_V_BP,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    output logic [10:0] h_cnt_o,
    output logic [10:0] v_cnt_o,
    output logic        active_o,
    output logic        line_last_o,
    output logic        frame_last_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [10:0] x_o,
    output logic [10:0] y_o,
    output logic        frame_start_o
);
    localparam int unsigned H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_DISP_C = 11'(H_DISP);
    localparam logic [10:0] HS_BEG_C = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_END_C = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST_C = 11'(H_TOT - 1);
    localparam logic [10:0] V_DISP_C = 11'(V_DISP);
    localparam logic [10:0] VS_BEG_C = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_END_C = 11'(V_DISP + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST_C = 11'(V_TOT - 1);

    logic [10:0] h_q, h_d, v_q, v_d;
    logic [10:0] x_q, y_q;
    logic        hsync_q, vsync_q, de_q, fs_q;
    logic        h_wrap, de_c, hs_act, vs_act, first_c;

    always_comb begin
        h_wrap  = (h_q == H_LAST_C);
        h_d     = h_wrap ? '0 : h_q + 11'd1;
        v_d     = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST_C) ? '0 : v_q + 11'd1;
        end
        de_c    = (h_q < H_DISP_C) && (v_q < V_DISP_C);
        hs_act  = (h_q >= HS_BEG_C) && (h_q < HS_END_C);
        vs_act  = (v_q >= VS_BEG_C) && (v_q < VS_END_C);
        first_c = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable_i) begin
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hs_act ? HS_POL : ~HS_POL;
            vsync_q <= vs_act ? VS_POL : ~VS_POL;
            de_q    <= de_c;
            x_q     <= de_c ? h_q : '0;
            y_q     <= de_c ? v_q : '0;
            fs_q    <= first_c;
        end
    end

    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign active_o      = de_c;
    assign line_last_o   = h_wrap;
    assign frame_last_o  = h_wrap && (v_q == V_LAST_C);
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = fs_q;

endmodule

// File: rtl/lcd_pattern_timing.sv
// LCD test-pattern generator: panel timing from lcd_sync_counter plus
// per-pixel colour generation, all outputs registered one clock after the
// counter state so sync, de, coordinates and colour stay aligned.
// Ports:
//   clk     pixel clock (only clock)
//   rst_n   synchronous active-low reset
//   enable  1 runs the timing, 0 holds counters at 0 and outputs idle
//   mode    requested pattern, adopted at the start of the next frame
//   lcd     video bus (master): hsync, vsync, de, R/G/B, x, y, frame_start
module lcd_pattern_timing
    import lcd_pattern_timing_pkg::*;
#(
    parameter int unsigned H_DISP = DEF_H_DISP,
    parameter int unsigned H_FP   = DEF_H_FP,
    parameter int unsigned H_SYNC = DEF_H_SYNC,
    parameter int unsigned H_BP   = DEF_H_BP,
    parameter int unsigned V_DISP = DEF_V_DISP,
    parameter int unsigned V_FP   = DEF_V_FP,
    parameter int unsigned V_SYNC = DEF_V_SYNC,
    parameter int unsigned V_BP   = DEF_V_BP,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0,
    parameter int unsigned R_W    = 5,
    parameter int unsigned G_W    = 6,
    parameter int unsigned B_W    = 5,
    parameter int unsigned BAR_W  = 16,
    parameter int unsigned CHK_SH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [2:0]           mode,
    lcd_pattern_timing_if.master lcd
);
    // Elaboration-time constant; the run-time bar index comes from counters.
    localparam int unsigned BAR_PX = H_DISP / NUM_BARS;

    localparam logic [10:0] BAR_PX_LAST_C = 11'(BAR_PX - 1);
    localparam logic [10:0] H_DISP_C      = 11'(H_DISP);
    localparam logic [10:0] H_DISP_LAST_C = 11'(H_DISP - 1);
    localparam logic [10:0] V_DISP_LAST_C = 11'(V_DISP - 1);
    localparam logic [3:0]  NUM_BARS_C    = 4'(NUM_BARS);

    logic [10:0] h_cnt, v_cnt;
    logic        active, line_last, frame_last, frame_first;

    mode_e          mode_q, mode_d, mode_eff;
    logic [10:0]    pos_q, pos_d;
    logic [10:0]    bpx_q, bpx_d;     // pixel within the current bar
    logic [3:0]     bidx_q, bidx_d;   // bar index; NUM_BARS = past the last bar
    logic [R_W-1:0] r_q, r_d;
    logic [G_W-1:0] g_q, g_d;
    logic [B_W-1:0] b_q, b_d;
    logic [2:0]     rgb_on;
    logic           ramp;

    lcd_sync_counter #(
        .H_DISP (H_DISP),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_DISP (V_DISP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .HS_POL (HS_POL),
        .VS_POL (VS_POL)
    ) u_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .active_o      (active),
        .line_last_o   (line_last),
        .frame_last_o  (frame_last),
        .hsync_o       (lcd.lcd_hsync),
        .vsync_o       (lcd.lcd_vsync),
        .de_o          (lcd.lcd_de),
        .x_o           (lcd.lcd_x),
        .y_o           (lcd.lcd_y),
        .frame_start_o (lcd.frame_start)
    );

    always_comb begin
        frame_first = (h_cnt == '0) && (v_cnt == '0);
        // A request seen on the frame's first pixel already colours it, so
        // the register only carries the mode through the rest of the frame.
        mode_eff    = frame_first ? mode_e'(mode) : mode_q;
        mode_d      = mode_eff;

        pos_d = pos_q;
        if (frame_last) begin
            pos_d = (pos_q == H_DISP_LAST_C) ? '0 : pos_q + 11'd1;
        end

        bpx_d  = bpx_q;
        bidx_d = bidx_q;
        if (line_last) begin
            bpx_d  = '0;
            bidx_d = '0;
        end else if ((h_cnt < H_DISP_C) && (bidx_q < NUM_BARS_C)) begin
            if (bpx_q == BAR_PX_LAST_C) begin
                bpx_d  = '0;
                bidx_d = bidx_q + 4'd1;
            end else begin
                bpx_d = bpx_q + 11'd1;
            end
        end

        rgb_on = 3'b000;
        ramp   = 1'b0;
        if (active) begin
            case (mode_eff)
                MODE_BARS: begin
                    if (bidx_q < NUM_BARS_C) rgb_on = BAR_RGB[bidx_q[2:0]];
                end
                MODE_RAMP: ramp = 1'b1;
                MODE_CHECKER: begin
                    if (h_cnt[CHK_SH] ^ v_cnt[CHK_SH]) rgb_on = 3'b111;
                end
                MODE_BORDER: begin
                    if ((h_cnt == '0) || (h_cnt == H_DISP_LAST_C) ||
                        (v_cnt == '0) || (v_cnt == V_DISP_LAST_C)) rgb_on = 3'b111;
                end
                MODE_MOVING_BAR: begin
                    // 12-bit compare so the bar never wraps past the right edge
                    if (({1'b0, h_cnt} >= {1'b0, pos_q}) &&
                        ({1'b0, h_cnt} < ({1'b0, pos_q} + 12'(BAR_W)))) rgb_on = 3'b111;
                end
                default: ;
            endcase
        end

        r_d = ramp ? R_W'(h_cnt) : {R_W{rgb_on[2]}};
        g_d = ramp ? G_W'(h_cnt) : {G_W{rgb_on[1]}};
        b_d = ramp ? B_W'(h_cnt) : {B_W{rgb_on[0]}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_BLACK;
            pos_q  <= '0;
            bpx_q  <= '0;
            bidx_q <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            mode_q <= mode_d;
            if (enable) begin
                pos_q  <= pos_d;
                bpx_q  <= bpx_d;
                bidx_q <= bidx_d;
                r_q    <= r_d;
                g_q    <= g_d;
                b_q    <= b_d;
            end else begin
                bpx_q  <= '0;
                bidx_q <= '0;
                r_q    <= '0;
                g_q    <= '0;
                b_q    <= '0;
            end
        end
    end

    assign lcd.LCD_R = r_q;
    assign lcd.LCD_G = g_q;
    assign lcd.LCD_B = b_q;

endmodule

// File: doc/lcd_pattern_timing.md
LCD_PATTERN_TIMING -- requirements
Module: lcd_pattern_timing

Interface
REQ-001 The module SHALL have parameters: H_DISP 480 (active pixels/line); H_FP 2; H_SYNC 41; H_BP 2; V_DISP 272 (active lines); V_FP 2; V_SYNC 10; V_BP 2; HS_POL 0 (active sync level); VS_POL 0; R_W 5, G_W 6, B_W 5 (colour channel widths); BAR_W 16 (moving-bar width, px); CHK_SH 4 (checker square = 2^CHK_SH px).
REQ-002 The module SHALL have port clk, input, 1: pixel clock, the only clock.
REQ-003 The module SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 The module SHALL have port enable, input, 1: run timing; 0 = hold idle.
REQ-005 The module SHALL have port mode, input, 3: requested pattern.
REQ-006 The module SHALL have ports lcd_hsync and lcd_vsync, output, 1 each: sync outputs at HS_POL/VS_POL when active.
REQ-007 The module SHALL have port lcd_de, output, 1: data enable.
REQ-008 The module SHALL have ports LCD_R (R_W), LCD_G (G_W) and LCD_B (B_W), outputs: pixel colour.
REQ-009 The module SHALL have ports lcd_x and lcd_y, outputs, 11 each: active pixel coordinate, aligned with lcd_de.
REQ-010 The module SHALL have port frame_start, output, 1: one-cycle pulse on the first active pixel of each frame.

Function
REQ-011 The module SHALL use an h_cnt counter running 0..H_TOT-1, where H_TOT = H_DISP+H_FP+H_SYNC+H_BP, and wrapping to 0.
REQ-012 The module SHALL increment v_cnt when h_cnt wraps; v_cnt SHALL run 0..V_TOT-1 and wrap, where V_TOT is defined likewise.
REQ-013 Region order SHALL be: active, front porch, sync, back porch; hsync SHALL be active for H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC, and vsync likewise on v_cnt.
REQ-014 de SHALL be defined as h_cnt<H_DISP and v_cnt<V_DISP.
REQ-015 All outputs SHALL be registered with a fixed latency of 1 clk from the counter state, and sync, de, xy and colour SHALL all be mutually aligned.
REQ-016 Colour outputs SHALL be 0 whenever lcd_de=0; lcd_x and lcd_y SHALL hold 0 outside the active region.
REQ-017 A mode change SHALL be latched into the active mode only when h_cnt=0 and v_cnt=0, and a mid-frame change SHALL never alter the current frame.
REQ-018 Modes SHALL be: 0 black; 1 eight vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black) of width H_DISP/8, with the remainder columns black; 2 horizontal ramp, each channel = x mod 2^width; 3 checkerboard, white where x[CHK_SH]^y[CHK_SH] is set, else black; 4 border, white on x=0, x=H_DISP-1, y=0, y=V_DISP-1, else black; 5 moving bar, white where pos <= x < pos+BAR_W, else black, with no wrap of the bar across the right edge; 6 and 7 black.
REQ-019 The bar index SHALL come from a per-line pixel counter with a bar counter, with no divider.
REQ-020 For mode 5, pos SHALL advance by 1 each frame and wrap to 0 when pos = H_DISP-1.
REQ-021 "White" SHALL mean all ones per channel.
REQ-022 When enable=0, the counters SHALL be held at 0 and the outputs SHALL be at idle values; when enable rises, the first cycle SHALL start at h_cnt=0, v_cnt=0.
REQ-023 frame_start SHALL be asserted with the pixel x=0, y=0.

Reset
REQ-024 On clk edge with rst_n=0, h_cnt, v_cnt, pos, the active mode and the bar counters SHALL go to 0.
REQ-025 During reset, lcd_hsync SHALL equal ~HS_POL, lcd_vsync SHALL equal ~VS_POL, lcd_de, frame_start, colour and xy SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL take effect on the next edge, and after release timing SHALL restart from h_cnt=0, v_cnt=0.

Structure
REQ-027 A shared package SHALL hold the mode encodings, the colour-bar RGB table and the default 480x272 timing constants.
REQ-028 The block SHALL contain one sub-module, lcd_sync_counter, holding the h/v counters, sync, de and position generation; colour generation SHALL sit in the parent.

Verification
Bench parameters: H_DISP=8, H_FP=2, H_SYNC=2, H_BP=2, V_DISP=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=VS_POL=0, BAR_W=2.
REQ-029 The bench SHALL cover: reset then enable=1 -> de high for 8 of every 14 clks, hsync low on clks 10-11 of each line, vsync low for line 5, frame period = 98 clks.
REQ-030 The bench SHALL cover: mode=1 -> line 0 colours white, yellow, cyan, green, magenta, red, blue, black (R,G,B = 31,63,31 first), one per pixel.
REQ-031 The bench SHALL cover: mode switched 1->4 at line 2 -> remainder of frame stays bars; next frame shows border (pixel (3,1)=0, pixel (7,2)=white).
REQ-032 The bench SHALL cover: mode=5 for 9 frames -> bar at x=0-1 on frame 0, x=6-7 on frame 6, x=7 only on frame 7, x=0-1 on frame 8.
REQ-033 The bench SHALL cover: rst_n=0 for 1 clk mid-line 2 -> next clk hsync=vsync=1, de=0, RGB=0; after release, frame_start pulses 1 clk later (latency 1).
REQ-034 The bench SHALL cover: enable dropped mid-frame -> outputs idle within 1 clk; re-enable -> frame_start after 1 clk.
